// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of the sram read port between instruction and data reads,
// plus a write port where debug writes always win over CPU data writes.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] ins_rd_addr,
  input  logic          ins_rd_req,
  output logic          ins_rd_rdy,
  output logic [DW-1:0] ins_rd_data,
  input  logic [AW-1:0] dat_rw_addr,
  input  logic          dat_rd_req,
  output logic          dat_rd_rdy,
  output logic [DW-1:0] dat_rd_data,
  input  logic          dat_wr_req,
  input  logic [DW-1:0] dat_wr_data,
  output logic          dat_wr_rdy,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_waddr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata
);
  logic ins_ack_q, dat_ack_q, wr_ack_q, dat_pref_q;
  logic ins_ack_d, dat_ack_d, wr_ack_d, dat_pref_d;
  logic ins_elig, dat_elig;
  // a requester being acked this cycle still holds req, so it must not be granted again
  always_comb begin
    ins_elig   = reset_n & ins_rd_req & ~ins_ack_q;
    dat_elig   = reset_n & dat_rd_req & ~dat_ack_q;
    ins_ack_d  = ins_elig & (~dat_elig | ~dat_pref_q);
    dat_ack_d  = dat_elig & ~ins_ack_d;
    dat_pref_d = (ins_ack_d | dat_ack_d) ? ins_ack_d : dat_pref_q;
    wr_ack_d   = reset_n & ~dbg_we & dat_wr_req & ~wr_ack_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ins_ack_q  <= 1'b0;
      dat_ack_q  <= 1'b0;
      wr_ack_q   <= 1'b0;
      dat_pref_q <= 1'b0;
    end else begin
      ins_ack_q  <= ins_ack_d;
      dat_ack_q  <= dat_ack_d;
      wr_ack_q   <= wr_ack_d;
      dat_pref_q <= dat_pref_d;
    end
  end
  assign mem_re      = ins_ack_d | dat_ack_d;
  assign mem_raddr   = dat_ack_d ? dat_rw_addr : ins_rd_addr;
  assign ins_rd_rdy  = ins_ack_q;
  assign dat_rd_rdy  = dat_ack_q;
  assign ins_rd_data = mem_rdata;
  assign dat_rd_data = mem_rdata;
  // debug writes bypass reset so the loader can fill memory while the CPU is held
  assign mem_we      = dbg_we | wr_ack_d;
  assign mem_waddr   = dbg_we ? dbg_waddr : dat_rw_addr;
  assign mem_wdata   = dbg_we ? dbg_wdata : dat_wr_data;
  assign dat_wr_rdy  = wr_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios against a registered, read-before-write sram model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] ins_rd_addr = '0, dat_rw_addr = '0, dat_wr_data = '0, dbg_waddr = '0, dbg_wdata = '0;
  logic        ins_rd_req = 1'b0, dat_rd_req = 1'b0, dat_wr_req = 1'b0, dbg_we = 1'b0;
  logic        ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, mem_re, mem_we;
  logic [15:0] ins_rd_data, dat_rd_data, mem_raddr, mem_waddr, mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] mem [0:65535];
  int n_cmp = 0;
  int n_fail = 0;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req), .ins_rd_rdy(ins_rd_rdy), .ins_rd_data(ins_rd_data),
    .dat_rw_addr(dat_rw_addr), .dat_rd_req(dat_rd_req), .dat_rd_rdy(dat_rd_rdy), .dat_rd_data(dat_rd_data),
    .dat_wr_req(dat_wr_req), .dat_wr_data(dat_wr_data), .dat_wr_rdy(dat_wr_rdy),
    .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_raddr];
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  task automatic dbg_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk); dbg_we = 1'b1; dbg_waddr = a; dbg_wdata = d;
    @(negedge clk); dbg_we = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic do_read(input logic sel_dat, input logic [15:0] a, output logic [15:0] d, output logic got);
    int n;
    got = 1'b0; d = '0; n = 0;
    @(negedge clk);
    if (sel_dat) begin dat_rw_addr = a; dat_rd_req = 1'b1; end
    else begin ins_rd_addr = a; ins_rd_req = 1'b1; end
    while (!got && n < 8) begin
      @(negedge clk); #1;
      if (sel_dat ? dat_rd_rdy : ins_rd_rdy) begin got = 1'b1; d = sel_dat ? dat_rd_data : ins_rd_data; end
      n++;
    end
    @(negedge clk); dat_rd_req = 1'b0; ins_rd_req = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0; ins_rd_req = 1'b1; dat_rd_req = 1'b1; dat_wr_req = 1'b1;
    #1;
    n_cmp++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL rst_mem_re got %b want 0", mem_re); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    @(negedge clk); #1;
    n_cmp++; if ({ins_rd_rdy, dat_rd_rdy, dat_wr_rdy} !== 3'b000) begin n_fail++; $display("FAIL rst_rdy got %b want 000", {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy}); end
    ins_rd_req = 1'b0; dat_rd_req = 1'b0; dat_wr_req = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    dbg_write(16'h0005, 16'h1234);
    @(negedge clk); ins_rd_addr = 16'h0005; ins_rd_req = 1'b1; #1;
    n_cmp++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL sr_grant_re got %b want 1", mem_re); end
    n_cmp++; if (mem_raddr !== 16'h0005) begin n_fail++; $display("FAIL sr_grant_addr got %h want 0005", mem_raddr); end
    n_cmp++; if (ins_rd_rdy !== 1'b0) begin n_fail++; $display("FAIL sr_early_rdy got %b want 0", ins_rd_rdy); end
    @(negedge clk); #1;
    n_cmp++; if (ins_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL sr_rdy got %b want 1", ins_rd_rdy); end
    n_cmp++; if (ins_rd_data !== 16'h1234) begin n_fail++; $display("FAIL sr_data got %h want 1234", ins_rd_data); end
    n_cmp++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL sr_no_regrant got %b want 0", mem_re); end
    @(negedge clk); ins_rd_req = 1'b0; #1;
    n_cmp++; if (ins_rd_rdy !== 1'b0) begin n_fail++; $display("FAIL sr_rdy_drop got %b want 0", ins_rd_rdy); end
  endtask

  task automatic test_round_robin();
    dbg_write(16'h0100, 16'hA0A0);
    dbg_write(16'h0200, 16'hD0D0);
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin ins_rd_addr = 16'h0100; dat_rw_addr = 16'h0200; ins_rd_req = 1'b1; dat_rd_req = 1'b1; end
      #1;
      n_cmp++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL rr_re c%0d got %b want 1", c, mem_re); end
      n_cmp++; if (mem_raddr !== ((c % 2 == 0) ? 16'h0100 : 16'h0200)) begin n_fail++; $display("FAIL rr_addr c%0d got %h want %h", c, mem_raddr, (c % 2 == 0) ? 16'h0100 : 16'h0200); end
      n_cmp++; if (ins_rd_rdy !== (c % 2 == 1)) begin n_fail++; $display("FAIL rr_ins_rdy c%0d got %b", c, ins_rd_rdy); end
      n_cmp++; if (dat_rd_rdy !== (c > 0 && c % 2 == 0)) begin n_fail++; $display("FAIL rr_dat_rdy c%0d got %b", c, dat_rd_rdy); end
      if (c % 2 == 1) begin n_cmp++; if (ins_rd_data !== 16'hA0A0) begin n_fail++; $display("FAIL rr_ins_data c%0d got %h want a0a0", c, ins_rd_data); end end
      if (c > 0 && c % 2 == 0) begin n_cmp++; if (dat_rd_data !== 16'hD0D0) begin n_fail++; $display("FAIL rr_dat_data c%0d got %h want d0d0", c, dat_rd_data); end end
    end
    @(negedge clk); ins_rd_req = 1'b0; dat_rd_req = 1'b0; #1;
    n_cmp++; if (dat_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL rr_last_rdy got %b want 1", dat_rd_rdy); end
    n_cmp++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL rr_idle_re got %b want 0", mem_re); end
    @(negedge clk);
  endtask

  task automatic test_write_stall();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin dat_rw_addr = 16'h0010; dat_wr_data = 16'hBEEF; dat_wr_req = 1'b1; end
      dbg_we = (c < 3); dbg_waddr = 16'h0040 + 16'(c); dbg_wdata = 16'h7700 + 16'(c);
      #1;
      n_cmp++; if (dat_wr_rdy !== (c == 4)) begin n_fail++; $display("FAIL ws_rdy c%0d got %b", c, dat_wr_rdy); end
      n_cmp++; if (mem_we !== (c < 4)) begin n_fail++; $display("FAIL ws_we c%0d got %b", c, mem_we); end
      if (c < 3) begin
        n_cmp++; if ({mem_waddr, mem_wdata} !== {16'h0040 + 16'(c), 16'h7700 + 16'(c)}) begin n_fail++; $display("FAIL ws_dbg c%0d got %h/%h", c, mem_waddr, mem_wdata); end
      end
      if (c == 3) begin
        n_cmp++; if ({mem_waddr, mem_wdata} !== {16'h0010, 16'hBEEF}) begin n_fail++; $display("FAIL ws_cpu got %h/%h want 0010/beef", mem_waddr, mem_wdata); end
      end
    end
    @(negedge clk); dat_wr_req = 1'b0; #1;
    n_cmp++; if (dat_wr_rdy !== 1'b0) begin n_fail++; $display("FAIL ws_rdy_drop got %b want 0", dat_wr_rdy); end
  endtask

  task automatic test_rd_wr_same();
    logic [15:0] d;
    logic got;
    dbg_write(16'h0020, 16'h1111);
    @(negedge clk); dat_rw_addr = 16'h0020; dat_wr_data = 16'h2222; dat_rd_req = 1'b1; dat_wr_req = 1'b1; #1;
    n_cmp++; if ({mem_re, mem_we} !== 2'b11) begin n_fail++; $display("FAIL rw_both got %b want 11", {mem_re, mem_we}); end
    @(negedge clk); #1;
    n_cmp++; if ({dat_rd_rdy, dat_wr_rdy} !== 2'b11) begin n_fail++; $display("FAIL rw_rdys got %b want 11", {dat_rd_rdy, dat_wr_rdy}); end
    n_cmp++; if (dat_rd_data !== 16'h1111) begin n_fail++; $display("FAIL rw_old got %h want 1111", dat_rd_data); end
    @(negedge clk); dat_rd_req = 1'b0; dat_wr_req = 1'b0;
    do_read(1'b1, 16'h0020, d, got);
    n_cmp++; if (!got || d !== 16'h2222) begin n_fail++; $display("FAIL rw_new got %h (rdy %b) want 2222", d, got); end
    do_read(1'b1, 16'h0010, d, got);
    n_cmp++; if (!got || d !== 16'hBEEF) begin n_fail++; $display("FAIL rw_cpu_wr got %h (rdy %b) want beef", d, got); end
    do_read(1'b0, 16'h0042, d, got);
    n_cmp++; if (!got || d !== 16'h7702) begin n_fail++; $display("FAIL rw_dbg_wr got %h (rdy %b) want 7702", d, got); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    logic got;
    do_read(1'b0, 16'h0005, d, got);
    n_cmp++; if (!got || d !== 16'h1234) begin n_fail++; $display("FAIL rm_pre got %h (rdy %b) want 1234", d, got); end
    @(negedge clk); ins_rd_addr = 16'h0100; dat_rw_addr = 16'h0200; ins_rd_req = 1'b1; dat_rd_req = 1'b1; #1;
    n_cmp++; if (mem_raddr !== 16'h0200) begin n_fail++; $display("FAIL rm_ptr_dat got %h want 0200", mem_raddr); end
    #1 reset_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_cmp++; if ({ins_rd_rdy, dat_rd_rdy, mem_re} !== 3'b000) begin n_fail++; $display("FAIL rm_in_rst c%0d got %b want 000", c, {ins_rd_rdy, dat_rd_rdy, mem_re}); end
    end
    @(negedge clk); reset_n = 1'b1; #1;
    n_cmp++; if ({mem_re, mem_raddr} !== {1'b1, 16'h0100}) begin n_fail++; $display("FAIL rm_ins_pref got %b/%h want 1/0100", mem_re, mem_raddr); end
    @(negedge clk); #1;
    n_cmp++; if ({ins_rd_rdy, ins_rd_data} !== {1'b1, 16'hA0A0}) begin n_fail++; $display("FAIL rm_ins_done got %b/%h want 1/a0a0", ins_rd_rdy, ins_rd_data); end
    n_cmp++; if (mem_raddr !== 16'h0200) begin n_fail++; $display("FAIL rm_dat_grant got %h want 0200", mem_raddr); end
    @(negedge clk); ins_rd_req = 1'b0; #1;
    n_cmp++; if ({dat_rd_rdy, dat_rd_data} !== {1'b1, 16'hD0D0}) begin n_fail++; $display("FAIL rm_dat_done got %b/%h want 1/d0d0", dat_rd_rdy, dat_rd_data); end
    @(negedge clk); dat_rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dbg_in_reset();
    logic [15:0] d;
    logic got;
    @(negedge clk);
    reset_n = 1'b0; dbg_we = 1'b1; dbg_waddr = 16'h8003; dbg_wdata = 16'h5A5A;
    ins_rd_req = 1'b1; dat_rd_req = 1'b1; dat_wr_req = 1'b1; dat_rw_addr = 16'h0030; dat_wr_data = 16'h3333;
    #1;
    n_cmp++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 16'h8003, 16'h5A5A}) begin n_fail++; $display("FAIL dr_dbg got %b/%h/%h want 1/8003/5a5a", mem_we, mem_waddr, mem_wdata); end
    n_cmp++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL dr_re got %b want 0", mem_re); end
    @(negedge clk); dbg_we = 1'b0; #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL dr_cpu_blocked got %b want 0", mem_we); end
    n_cmp++; if ({ins_rd_rdy, dat_rd_rdy, dat_wr_rdy} !== 3'b000) begin n_fail++; $display("FAIL dr_rdy got %b want 000", {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy}); end
    @(negedge clk); ins_rd_req = 1'b0; dat_rd_req = 1'b0; dat_wr_req = 1'b0; reset_n = 1'b1;
    do_read(1'b0, 16'h8003, d, got);
    n_cmp++; if (!got || d !== 16'h5A5A) begin n_fail++; $display("FAIL dr_readback got %h (rdy %b) want 5a5a", d, got); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_stall();
    test_rd_wr_same();
    test_reset_mid();
    test_dbg_in_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
